// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: per-channel tick pulses and 50% squares
// with shadowed divisors that take effect at wrap or sync_clear, plus a free-running count.
module clock_divider_multi #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DEFAULT_DIV = 24999999
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic                                         enable,
  input  logic                                         sync_clear,
  input  logic                                         wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan,
  input  logic [WIDTH-1:0]                             wr_div,
  output logic [CHANNELS-1:0]                          tick,
  output logic [CHANNELS-1:0]                          square,
  output logic [WIDTH-1:0]                             free_count
);

  localparam int unsigned WC = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    r_cnt   [CHANNELS];
  logic [WIDTH-1:0]    r_act   [CHANNELS];
  logic [WIDTH-1:0]    r_shd   [CHANNELS];
  logic [CHANNELS-1:0] r_tick;
  logic [CHANNELS-1:0] r_square;
  logic [WIDTH-1:0]    r_free;

  logic [CHANNELS-1:0] w_hit;
  logic [CHANNELS-1:0] w_wrap;
  logic [WIDTH-1:0]    w_next_div [CHANNELS];

  // Out-of-range channel indices match no channel, so those writes drop naturally.
  // A write landing on a wrap/clear edge bypasses the shadow into the active divisor.
  always_comb begin
    w_hit  = '0;
    w_wrap = '0;
    for (int ch = 0; ch < int'(CHANNELS); ch++) begin
      w_next_div[ch] = r_shd[ch];
      w_hit[ch]      = wr_en && (wr_chan == WC'(ch));
      w_wrap[ch]     = (r_cnt[ch] == r_act[ch]);
      if (w_hit[ch]) w_next_div[ch] = wr_div;
    end
  end

  // Per-channel counters; sync_clear outranks counting, enable gates counting only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        r_cnt[ch] <= '0;
        r_act[ch] <= DEF_DIV;
        r_shd[ch] <= DEF_DIV;
      end
      r_tick   <= '0;
      r_square <= '0;
    end else begin
      for (int ch = 0; ch < int'(CHANNELS); ch++) begin
        if (sync_clear) begin
          r_cnt[ch]    <= '0;
          r_tick[ch]   <= 1'b0;
          r_square[ch] <= 1'b0;
          r_act[ch]    <= w_next_div[ch];
        end else if (enable) begin
          if (w_wrap[ch]) begin
            r_cnt[ch]    <= '0;
            r_tick[ch]   <= 1'b1;
            r_square[ch] <= ~r_square[ch];
            r_act[ch]    <= w_next_div[ch];
          end else begin
            r_cnt[ch]  <= r_cnt[ch] + WIDTH'(1);
            r_tick[ch] <= 1'b0;
          end
        end else begin
          r_tick[ch] <= 1'b0;
        end
        if (w_hit[ch]) r_shd[ch] <= wr_div;
      end
    end
  end

  // Legacy free-running count, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_free <= '0;
    else        r_free <= r_free + WIDTH'(1);
  end

  assign tick       = r_tick;
  assign square     = r_square;
  assign free_count = r_free;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi: five channels, DEFAULT_DIV shortened to 7.
module tb_clock_divider_multi;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CH    = 5;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             sync_clear;
  logic             wr_en;
  logic [2:0]       wr_chan;
  logic [WIDTH-1:0] wr_div;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    square;
  logic [WIDTH-1:0] free_count;

  int          errors;
  int          checks;
  int unsigned exp_fc;

  clock_divider_multi #(.WIDTH(WIDTH), .CHANNELS(CH), .DEFAULT_DIV(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .sync_clear (sync_clear),
    .wr_en      (wr_en),
    .wr_chan    (wr_chan),
    .wr_div     (wr_div),
    .tick       (tick),
    .square     (square),
    .free_count (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock; sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (reset) exp_fc++;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; sync_clear = 1'b0; wr_en = 1'b0;
    wr_chan = '0; wr_div = '0; exp_fc = 0;
    cyc(); cyc();
    checks++;
    if (tick !== '0 || square !== '0 || free_count !== '0) begin
      errors++;
      $display("FAIL reset_state: tick=%b square=%b fc=%0d, want 0/0/0", tick, square, free_count);
    end
    #2 reset = 1'b1;
  endtask

  task automatic test_basic_div3();
    logic et, es;
    wr_en = 1'b1; wr_chan = 3'd0; wr_div = 3; sync_clear = 1'b1; enable = 1'b0;
    cyc();
    wr_en = 1'b0; sync_clear = 1'b0; enable = 1'b1;
    checks++;
    if (tick !== '0 || square !== '0) begin
      errors++;
      $display("FAIL clear_state: tick=%b square=%b, want 0", tick, square);
    end
    for (int k = 1; k <= 16; k++) begin
      cyc();
      et = (k % 4 == 0);
      es = ((k / 4) % 2 == 1);
      checks++;
      if ({tick[0], square[0]} !== {et, es}) begin
        errors++;
        $display("FAIL div3 k=%0d: tick0/sq0=%b%b, want %b%b", k, tick[0], square[0], et, es);
      end
    end
    checks++;
    if (free_count !== WIDTH'(exp_fc)) begin
      errors++;
      $display("FAIL free_count_div3: got %0d, want %0d", free_count, exp_fc);
    end
  endtask

  task automatic test_midperiod_write();
    logic et;
    sync_clear = 1'b1; enable = 1'b1;
    cyc();
    sync_clear = 1'b0;
    cyc();
    wr_en = 1'b1; wr_chan = 3'd0; wr_div = 1;
    for (int k = 2; k <= 12; k++) begin
      cyc();
      wr_en = 1'b0;
      et = (k == 4) || (k > 4 && (k % 2 == 0));
      checks++;
      if (tick[0] !== et) begin
        errors++;
        $display("FAIL midwrite k=%0d: tick0=%b, want %b", k, tick[0], et);
      end
    end
  endtask

  task automatic test_multi_channel();
    logic [2:0] et, es;
    enable = 1'b0; wr_en = 1'b1;
    wr_chan = 3'd1; wr_div = 0; cyc();
    wr_chan = 3'd2; wr_div = 4; cyc();
    wr_chan = 3'd3; wr_div = 9; cyc();
    wr_en = 1'b0; sync_clear = 1'b1;
    cyc();
    sync_clear = 1'b0; enable = 1'b1;
    checks++;
    if (square !== '0 || tick !== '0) begin
      errors++;
      $display("FAIL multi_clear: tick=%b square=%b, want 0", tick, square);
    end
    for (int k = 1; k <= 20; k++) begin
      cyc();
      et = {(k % 10 == 0), (k % 5 == 0), 1'b1};
      es = {((k / 10) % 2 == 1), ((k / 5) % 2 == 1), (k % 2 == 1)};
      checks++;
      if (tick[3:1] !== et || square[3:1] !== es) begin
        errors++;
        $display("FAIL multi k=%0d: tick[3:1]=%b sq[3:1]=%b, want %b %b", k, tick[3:1], square[3:1], et, es);
      end
    end
  endtask

  task automatic test_enable_gap();
    wr_en = 1'b1; wr_chan = 3'd0; wr_div = 5; sync_clear = 1'b1; enable = 1'b1;
    cyc();
    wr_en = 1'b0; sync_clear = 1'b0;
    cyc(); cyc();
    enable = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      checks++;
      if (tick[0] !== 1'b0 || square[0] !== 1'b0) begin
        errors++;
        $display("FAIL gap k=%0d: tick0=%b sq0=%b, want 0 0", k, tick[0], square[0]);
      end
    end
    checks++;
    if (free_count !== WIDTH'(exp_fc)) begin
      errors++;
      $display("FAIL gap_free_count: got %0d, want %0d", free_count, exp_fc);
    end
    enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      checks++;
      if (tick[0] !== (k == 4) || square[0] !== (k == 4)) begin
        errors++;
        $display("FAIL resume k=%0d: tick0=%b sq0=%b, want %b", k, tick[0], square[0], (k == 4));
      end
    end
  endtask

  task automatic test_clear_write_and_range();
    int divs [CH];
    logic [CH-1:0] et;
    divs = '{5, 0, 2, 9, 7};
    wr_en = 1'b1; wr_chan = 3'd2; wr_div = 2; sync_clear = 1'b1; enable = 1'b1;
    cyc();
    wr_en = 1'b0; sync_clear = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      checks++;
      if (tick[2] !== (k % 3 == 0)) begin
        errors++;
        $display("FAIL clear_write k=%0d: tick2=%b, want %b", k, tick[2], (k % 3 == 0));
      end
    end
    enable = 1'b0; wr_en = 1'b1; wr_chan = 3'd5; wr_div = 0;
    cyc();
    wr_en = 1'b0; sync_clear = 1'b1;
    cyc();
    sync_clear = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      for (int c = 0; c < int'(CH); c++) et[c] = (k % (divs[c] + 1) == 0);
      checks++;
      if (tick !== et) begin
        errors++;
        $display("FAIL out_of_range k=%0d: tick=%b, want %b", k, tick, et);
      end
    end
  endtask

  task automatic test_async_reset();
    cyc(); cyc();
    #3 reset = 1'b0;
    #1;
    exp_fc = 0;
    checks++;
    if (tick !== '0 || square !== '0 || free_count !== '0) begin
      errors++;
      $display("FAIL async_reset: tick=%b square=%b fc=%0d, want 0/0/0", tick, square, free_count);
    end
    #2 reset = 1'b1; enable = 1'b1; sync_clear = 1'b0; wr_en = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++;
      if (tick !== ((k == 8) ? 5'h1f : 5'h00)) begin
        errors++;
        $display("FAIL default_div k=%0d: tick=%b, want %b", k, tick, ((k == 8) ? 5'h1f : 5'h00));
      end
    end
    checks++;
    if (free_count !== WIDTH'(exp_fc) || square !== 5'h1f) begin
      errors++;
      $display("FAIL post_reset: fc=%0d sq=%b, want %0d 11111", free_count, square, exp_fc);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_div3();
    test_midperiod_write();
    test_multi_channel();
    test_enable_gap();
    test_clear_write_and_range();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
